// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: instruction-bus request/response, decode payload and FSM states.
// FETCH_MISALIGN_CHECK_EN adds a misalign flag to the decode payload.
package fetch_stage_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  function automatic fetch_data_t make_fetch(logic [63:0] pc, logic [31:0] instr);
    fetch_data_t d;
    d.valid     = 1'b1;
    d.pc        = pc;
    d.raw_instr = instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    d.misalign  = 1'b0;
`endif
    return d;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Next fetch-PC mux: a redirect target beats the sequential advance, otherwise the PC holds.
module pc_select (
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic [63:0] pc,
  input  logic        advance,
  output logic [63:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = pc + 64'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: one outstanding bus request, one-entry skid buffer, redirect flush.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned PC trapped locally instead of fetched).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t dataF
);

  fetch_state_t state_p0;
  fetch_state_t state_next;
  logic [63:0]  pc_p0;
  logic [63:0]  pc_next;
  logic [63:0]  drop_addr_p0;
  logic [63:0]  drop_addr_next;
  fetch_data_t  data_p1;
  fetch_data_t  data_next;
  fetch_data_t  skid_p1;
  fetch_data_t  skid_next;
  logic         advance;
  logic         out_free;
  logic         misaligned;

  pc_select u_pc_select (
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc_p0),
    .advance        (advance),
    .next_pc        (pc_next)
  );

  assign out_free = !data_p1.valid || !stallF;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (state_p0 == FETCH) && (pc_p0[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_next     = state_p0;
    data_next      = data_p1;
    skid_next      = skid_p1;
    drop_addr_next = drop_addr_p0;
    advance        = 1'b0;
    ireq.valid     = 1'b0;
    ireq.addr      = pc_p0;

    case (state_p0)
      FETCH: begin
        if (misaligned) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (out_free) begin
            data_next          = make_fetch(pc_p0, 32'd0);
            data_next.misalign = 1'b1;
          end
`endif
        end else begin
          ireq.valid = 1'b1;
          if (iresp.data_ok) begin
            advance = 1'b1;
            if (out_free) begin
              data_next = make_fetch(pc_p0, iresp.data);
            end else begin
              skid_next  = make_fetch(pc_p0, iresp.data);
              state_next = HOLD;
            end
          end else if (!stallF) begin
            data_next.valid = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!stallF) begin
          data_next       = skid_p1;
          skid_next.valid = 1'b0;
          state_next      = FETCH;
        end
      end
      DROP: begin
        // The stale request must still complete on the bus at its original address.
        ireq.valid = 1'b1;
        ireq.addr  = drop_addr_p0;
        if (iresp.data_ok) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

    if (redirect_valid) begin
      data_next.valid = 1'b0;
      skid_next.valid = 1'b0;
      case (state_p0)
        FETCH: begin
          if (!misaligned && !iresp.data_ok) begin
            state_next     = DROP;
            drop_addr_next = pc_p0;
          end else begin
            state_next = FETCH;
          end
        end
        DROP:    state_next = iresp.data_ok ? FETCH : DROP;
        default: state_next = FETCH;
      endcase
    end
  end

  // Stage boundary: architectural PC, FSM state, decode out-register and skid entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p0 <= FETCH;
      pc_p0    <= RESET_PC;
      data_p1  <= '0;
      skid_p1  <= '0;
    end else begin
      state_p0 <= state_next;
      pc_p0    <= pc_next;
      data_p1  <= data_next;
      skid_p1  <= skid_next;
    end
  end

  always_ff @(posedge clk) begin
    drop_addr_p0 <= drop_addr_next;
  end

  assign dataF = data_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then randomized bus latency, stalls and redirects
// checked against a transaction-level model of the fetched instruction stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stallF;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq           (ireq),
    .iresp          (iresp),
    .stallF         (stallF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF          (dataF)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 1;
  int gen         = 0;
  int delivered   = 0;
  logic        bus_busy = 1'b0;
  logic [63:0] bus_addr = '0;
  int          bus_cnt  = 0;
  int          bus_gen  = 0;
  logic [63:0] exp_fetch_pc = RST_PC;
  logic [63:0] pend_q[$];
  fetch_data_t prev_data;
  fetch_data_t obs_data;
  ibus_req_t   obs_req;
  logic        prev_hold     = 1'b0;
  logic        prev_redirect = 1'b0;
  logic        prev_req_wait = 1'b0;
  logic        expect_now    = 1'b0;
  logic [63:0] prev_req_addr = '0;

  function automatic logic [31:0] mem(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bus_busy      = 1'b0;
    gen++;
    pend_q.delete();
    exp_fetch_pc  = RST_PC;
    prev_hold     = 1'b0;
    prev_redirect = 1'b0;
    prev_req_wait = 1'b0;
    expect_now    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    resetn         = 1'b0;
    stallF         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp          = '0;
    #1;
    chk("reset_async_dataF", 128'(dataF), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // One clock cycle: check the DUT against the stream model, act as the bus, drive inputs.
  task automatic tick(input logic stall, input logic redir, input logic [63:0] rpc);
    logic        ok;
    logic [63:0] exp_pc;
    @(negedge clk);
    obs_data = dataF;
    obs_req  = ireq;
    if (prev_redirect) begin
      chk("valid_after_redirect", 128'(dataF.valid), 128'(0));
    end else if (prev_hold) begin
      chk("stable_while_stalled", 128'(dataF), 128'(prev_data));
    end else if (dataF.valid) begin
      chk("unexpected_delivery", 128'(pend_q.size() != 0), 128'(1));
      if (pend_q.size() != 0) begin
        exp_pc = pend_q.pop_front();
        chk("dataF_pc", 128'(dataF.pc), 128'(exp_pc));
        chk("dataF_instr", 128'(dataF.raw_instr), 128'(mem(exp_pc)));
        delivered++;
      end
    end
    if (expect_now) chk("latency", 128'(dataF.valid), 128'(1));
    if (pend_q.size() != 0) chk("no_req_while_skid_full", 128'(ireq.valid), 128'(0));
    if (prev_req_wait) chk("req_held", 128'({ireq.valid, ireq.addr}), 128'({1'b1, prev_req_addr}));

    if (ireq.valid && !bus_busy) begin
      chk("req_addr", 128'(ireq.addr), 128'(exp_fetch_pc));
      bus_busy = 1'b1;
      bus_addr = ireq.addr;
      bus_cnt  = lat;
      bus_gen  = gen;
    end
    ok = bus_busy && (bus_cnt == 0);
    if (bus_busy && bus_cnt != 0) bus_cnt--;

    stallF         = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    iresp.data_ok  = ok;
    iresp.data     = ok ? mem(bus_addr) : 32'($urandom);

    prev_hold     = dataF.valid && stall && !redir;
    prev_redirect = redir;
    prev_data     = dataF;
    prev_req_wait = ireq.valid && !ok;
    prev_req_addr = ireq.addr;
    expect_now    = 1'b0;
    if (ok) begin
      bus_busy = 1'b0;
      if (bus_gen == gen && !redir) begin
        pend_q.push_back(bus_addr);
        exp_fetch_pc = bus_addr + 64'd4;
        expect_now   = !(dataF.valid && stall);
      end
    end
    if (redir) begin
      gen++;
      pend_q.delete();
      exp_fetch_pc = rpc;
    end
  endtask

  initial begin
    logic        st;
    logic        rd;
    logic [63:0] rp;
    resetn         = 1'b0;
    stallF         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp          = '0;

    // Sequential fetch with 1-cycle bus latency
    do_reset();
    lat = 1;
    tick(1'b0, 1'b0, '0);
    chk("t1_first_req", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, RST_PC}));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("t1_data0", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, RST_PC}));
    chk("t1_req1", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, RST_PC + 64'd4}));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("t1_data1", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, RST_PC + 64'd4}));
    chk("t1_req2", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, RST_PC + 64'd8}));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("t1_data2", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, RST_PC + 64'd8}));

    // Stall with a response arriving: skid, HOLD, then drain
    do_reset();
    lat = 1;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("t2_data0", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, RST_PC}));
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("t2_hold_noreq", 128'(obs_req.valid), 128'(0));
    chk("t2_hold_data", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, RST_PC}));
    tick(1'b0, 1'b0, '0);
    lat = 4;
    tick(1'b0, 1'b0, '0);
    chk("t2_skid_out", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, RST_PC + 64'd4}));
    chk("t2_next_req", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, RST_PC + 64'd8}));

    // Redirect while a request is outstanding: DROP keeps the stale address
    tick(1'b0, 1'b1, 64'h8000_1000);
    tick(1'b0, 1'b0, '0);
    chk("t3_valid_cleared", 128'(obs_data.valid), 128'(0));
    chk("t3_drop_addr", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, RST_PC + 64'd8}));
    tick(1'b0, 1'b0, '0);
    lat = 1;
    tick(1'b0, 1'b0, '0);
    chk("t3_drop_addr_late", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, RST_PC + 64'd8}));
    tick(1'b0, 1'b0, '0);
    chk("t3_redirect_req", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, 64'h8000_1000}));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("t3_redirect_data", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, 64'h8000_1000}));

    // Redirect in the same cycle as data_ok
    tick(1'b0, 1'b1, 64'h8000_2000);
    tick(1'b0, 1'b0, '0);
    chk("t4_valid_cleared", 128'(obs_data.valid), 128'(0));
    chk("t4_req", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, 64'h8000_2000}));
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("t4_data", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, 64'h8000_2000}));

    // Redirect while in HOLD
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 64'h8000_3000);
    chk("t5_hold_noreq", 128'(obs_req.valid), 128'(0));
    tick(1'b0, 1'b0, '0);
    chk("t5_valid_cleared", 128'(obs_data.valid), 128'(0));
    chk("t5_req", 128'({obs_req.valid, obs_req.addr}), 128'({1'b1, 64'h8000_3000}));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("t5_data", 128'({obs_data.valid, obs_data.pc}), 128'({1'b1, 64'h8000_3000}));

    // Randomized latency, stalls and redirects (including a target that wraps past 2^64)
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      lat = $urandom_range(0, 3);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
      else rp = {32'h0, 32'h8000_0000 + (32'($urandom_range(0, 1023)) << 2)};
      tick(st, rd, rp);
    end
    chk("progress", 128'(delivered > 200), 128'(1));

`ifdef FETCH_MISALIGN_CHECK_EN
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = RST_PC + 64'd2;
    iresp.data_ok  = 1'b1;
    iresp.data     = 32'h0;
    stallF         = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    iresp.data_ok  = 1'b0;
    chk("mis_noreq", 128'(ireq.valid), 128'(0));
    @(negedge clk);
    chk("mis_data", 128'({dataF.valid, dataF.misalign, dataF.pc}), 128'({1'b1, 1'b1, RST_PC + 64'd2}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
